// File: rtl/regfile_pkg.sv
// Shared widths and write-stage FSM encoding for the register file write arbiter.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HELD  = 2'd2
  } state_t;
endpackage

// File: rtl/decoder5to32.sv
// Register file write-port decoder: one-hot of sel when enabled, all zero otherwise.
module decoder5to32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter between ALU and load writeback into a single-entry
// output stage that drives the register file write port.
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                wr_stall,
  output logic                dec_enable,
  output logic [ADDR_W-1:0]   dec_select,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] pend_mask,
  output state_t              dbg_state
);
  state_t            state;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic              ptr;        // 0: requester 0 wins the next conflict
  logic              accept_ok;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Handshake: a write transfers on a cycle where valid and ready are both high.
  // ready is combinational from valid, state, wr_stall and ptr; the requester
  // holds valid/addr/data until it sees ready.
  always_comb begin
    accept_ok = !reset && ((state == IDLE) || (state == WRITE && !wr_stall));
    grant0    = accept_ok && req0_valid && (!req1_valid || !ptr);
    grant1    = accept_ok && req1_valid && (!req0_valid ||  ptr);
    accept    = grant0 || grant1;
    acc_addr  = grant1 ? req1_addr : req0_addr;
    acc_data  = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign dec_enable = (state == WRITE) && !wr_stall;
  assign dec_select = stage_addr;
  assign wr_data    = stage_data;
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stage_addr <= '0;
      stage_data <= '0;
      ptr        <= 1'b0;
    end else begin
      if (accept) ptr <= grant0;
      case (state)
        IDLE, WRITE: begin
          if (state == WRITE && wr_stall) begin
            state <= HELD;
          end else if (accept && acc_addr != '0) begin
            state      <= WRITE;
            stage_addr <= acc_addr;
            stage_data <= acc_data;
          end else begin
            // Register 0 writes land here too: accepted, then dropped.
            state      <= IDLE;
            stage_addr <= '0;
            stage_data <= '0;
          end
        end
        HELD: begin
          if (!wr_stall) state <= WRITE;
        end
        default: begin
          state      <= IDLE;
          stage_addr <= '0;
          stage_data <= '0;
        end
      endcase
    end
  end

  decoder5to32 u_pend_dec (
    .en  (state != IDLE),
    .sel (stage_addr),
    .y   (pend_mask)
  );
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and randomized checks of regfile_wr_arbiter against a queue-based model.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req1_valid, wr_stall;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, dec_enable;
  logic [4:0]  dec_select;
  logic [31:0] wr_data, pend_mask;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: exp_q is the output stage ({addr,data}, 0 or 1 entries).
  logic [36:0] exp_q[$];
  bit          m_held;
  bit          m_ptr;
  bit          acc0, acc1;
  int          w7_cnt;
  logic [36:0] commit_log[$];
  int          grant_log[$];

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_stall   (wr_stall),
    .dec_enable (dec_enable),
    .dec_select (dec_select),
    .wr_data    (wr_data),
    .pend_mask  (pend_mask),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    wr_stall   = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    commit_log.delete();
    grant_log.delete();
    m_held = 1'b0;
    m_ptr  = 1'b0;
    acc0   = 1'b0;
    acc1   = 1'b0;
    w7_cnt = 0;
  endtask

  // One clock: check at negedge against the model, advance model, return at posedge+1.
  task automatic cycle();
    bit          have, acc_ok, g0, g1, en;
    logic [36:0] front;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    have   = (exp_q.size() != 0);
    front  = have ? exp_q[0] : 37'd0;
    acc_ok = !have || (!m_held && !wr_stall);
    g0 = 1'b0;
    g1 = 1'b0;
    if (acc_ok && req0_valid && req1_valid) begin
      g0 = !m_ptr;
      g1 =  m_ptr;
    end else if (acc_ok) begin
      g0 = req0_valid;
      g1 = req1_valid;
    end
    en = have && !m_held && !wr_stall;
    check("req0_ready", 64'(req0_ready), 64'(g0));
    check("req1_ready", 64'(req1_ready), 64'(g1));
    check("dec_enable", 64'(dec_enable), 64'(en));
    check("dec_select", 64'(dec_select), 64'(front[36:32]));
    check("wr_data",    64'(wr_data),    64'(front[31:0]));
    check("pend_mask",  64'(pend_mask),  have ? 64'(32'd1 << front[36:32]) : 64'd0);
    if (dec_enable) begin
      commit_log.push_back({dec_select, wr_data});
      if (dec_select == 5'd7) w7_cnt++;
    end
    if (req0_ready) grant_log.push_back(0);
    if (req1_ready) grant_log.push_back(1);
    acc0 = g0;
    acc1 = g1;
    if (en) void'(exp_q.pop_front());
    else if (have) m_held = wr_stall;
    if (g0 || g1) begin
      a = g0 ? req0_addr : req1_addr;
      d = g0 ? req0_data : req1_data;
      m_ptr = g0;
      if (a != 5'd0) exp_q.push_back({a, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready0"}, 64'(req0_ready), 64'd0);
    check({tag, "_ready1"}, 64'(req1_ready), 64'd0);
    check({tag, "_en"},     64'(dec_enable), 64'd0);
    check({tag, "_sel"},    64'(dec_select), 64'd0);
    check({tag, "_data"},   64'(wr_data),    64'd0);
    check({tag, "_pend"},   64'(pend_mask),  64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 5'd4;
    req1_addr  = 5'd6;
    @(negedge clk);
    check_zero_outputs("rst");
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  initial begin
    idle_inputs();
    model_reset();

    // Single write, one-cycle latency
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    check("t035_count", 64'(commit_log.size()), 64'd1);
    if (commit_log.size() == 1)
      check("t035_commit", 64'(commit_log[0]), 64'({5'd5, 32'hDEADBEEF}));

    // Back-to-back conflicts alternate
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1;
    req1_valid = 1'b1; req1_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      req0_data = $urandom;
      req1_data = $urandom;
      cycle();
    end
    idle_inputs();
    cycle();
    check("t036_grants", 64'(grant_log.size()), 64'd4);
    check("t036_count",  64'(commit_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("t036_grant", 64'(grant_log[i]), 64'(i % 2));
    for (int i = 0; i < 4 && i < commit_log.size(); i++)
      check("t036_sel", 64'(commit_log[i][36:32]), 64'((i % 2) + 1));

    // Stall holds the stage, one commit after release
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_3333;
    cycle();
    idle_inputs();
    wr_stall = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h9;
    for (int i = 0; i < 3; i++) cycle();
    check("t037_nocommit", 64'(commit_log.size()), 64'd0);
    req1_valid = 1'b0;
    wr_stall = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("t037_count", 64'(commit_log.size()), 64'd1);
    if (commit_log.size() == 1)
      check("t037_commit", 64'(commit_log[0]), 64'({5'd3, 32'h0000_3333}));

    // Register 0 write dropped but advances round-robin
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    cycle();
    idle_inputs();
    cycle();
    check("t038_nocommit", 64'(commit_log.size()), 64'd0);
    req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAA;
    cycle();
    check("t038_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2)
      check("t038_second", 64'(grant_log[1]), 64'd0);
    idle_inputs();
    cycle();

    // Asynchronous reset during HELD discards the write
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h7777_7777;
    cycle();
    req0_valid = 1'b0;
    wr_stall = 1'b1;
    cycle();
    cycle();
    check("t039_held", 64'(dbg_state), 64'(HELD));
    #2;
    reset = 1'b1;
    req0_valid = 1'b1;
    #1;
    check_zero_outputs("t039");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();
    check("t039_no_w7", 64'(w7_cnt), 64'd0);

    // Randomized traffic with held-until-accepted requests
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_addr  = 5'($urandom_range(0, 31));
        req0_data  = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_addr  = 5'($urandom_range(0, 31));
        req1_data  = $urandom;
      end
      wr_stall = ($urandom_range(0, 99) < 25);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameters: none; widths fixed by package constants (ADDR_W=5, DATA_W=32, NUM_REGS=32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_addr  input  5  requester 0 destination register.
REQ-006 req0_data  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 write accepted this cycle when high with req0_valid.
REQ-008 req1_valid  input  1  requester 1 (load writeback) has a write pending.
REQ-009 req1_addr  input  5  requester 1 destination register.
REQ-010 req1_data  input  32  requester 1 write data.
REQ-011 req1_ready  output  1  requester 1 write accepted this cycle when high with req1_valid.
REQ-012 wr_stall  input  1  register file cannot take a write this cycle.
REQ-013 dec_enable  output  1  write-port decoder enable; one cycle high per committed write.
REQ-014 dec_select  output  5  write-port decoder select (destination register).
REQ-015 wr_data  output  32  data presented to the register file write port.
REQ-016 pend_mask  output  32  one-hot of register held in the output stage; all zero when stage empty.

Function
REQ-017 Output stage is a single register (addr, data, valid); FSM states IDLE (stage empty), WRITE (stage full, committing), HELD (stage full, wr_stall high).
REQ-018 IDLE: on accept -> WRITE; else stay IDLE.
REQ-019 WRITE: wr_stall=1 -> HELD; wr_stall=0 and new accept -> WRITE; wr_stall=0 and no accept -> IDLE.
REQ-020 HELD: wr_stall=1 -> stay HELD; wr_stall=0 -> WRITE (same contents, committed next cycle).
REQ-021 dec_enable = 1 only in WRITE with wr_stall=0; dec_select/wr_data = stage contents in WRITE and HELD, zero in IDLE.
REQ-022 Accept possible when state is IDLE, or WRITE with wr_stall=0; never in HELD or WRITE with wr_stall=1.
REQ-023 Latency: request accepted in cycle N appears with dec_enable=1 in cycle N+1 absent stall; back-to-back throughput one write per cycle.
REQ-024 Single valid requester when accept possible: that requester's ready=1.
REQ-025 Both valid: round-robin; grant goes to requester not granted last; only the granted ready is high.
REQ-026 Round-robin pointer updates only on an actual accept; unchanged on idle or stall cycles.
REQ-027 ready outputs combinational from valid, state, wr_stall and pointer; never both high in one cycle.
REQ-028 Writes to register 0 are accepted (ready high) but discarded: stage stays/returns empty, no dec_enable, pointer still advances.
REQ-029 pend_mask = one-hot(dec_select) while state is WRITE or HELD; zero in IDLE.
REQ-030 Requester must hold valid/addr/data stable until accepted; block does not buffer unaccepted requests.

Reset
REQ-031 reset high: state=IDLE, stage addr/data=0, pointer selects requester 0 first, dec_enable=0, dec_select=0, wr_data=0, pend_mask=0, both ready=0 while reset high.
REQ-032 reset mid-WRITE or HELD: pending write discarded, never committed after reset release.

Structure
REQ-033 Package regfile_pkg holds ADDR_W, DATA_W, NUM_REGS and the FSM state enum (IDLE, WRITE, HELD).
REQ-034 pend_mask generated by one instance of the existing decoder5to32, enable tied to stage-valid, select from stage addr.

Verification
REQ-035 After reset, req0 valid addr=5 data=0xDEADBEEF -> req0_ready=1 cycle N; cycle N+1 dec_enable=1, dec_select=5, wr_data=0xDEADBEEF, pend_mask=0x00000020.
REQ-036 Both valid every cycle (req0 addr=1, req1 addr=2) for 4 cycles -> grants 0,1,0,1; dec_select sequence 1,2,1,2 with no idle cycles.
REQ-037 Write to addr=3 accepted, wr_stall=1 for 3 cycles -> dec_enable=0, dec_select=3 held, ready=0; stall drops -> exactly one dec_enable pulse.
REQ-038 req1 valid addr=0 -> req1_ready=1, dec_enable stays 0, pend_mask=0; next conflict grants req0.
REQ-039 reset asserted asynchronously during HELD with addr=7 -> outputs zero immediately; after release no write to register 7 ever issued.
